// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial sequence detector: state encodings,
// datapath widths, the pattern-length field type and the length mask helper.
package seq_det_pkg;

  localparam int PAT_W = 8;
  localparam int CNT_W = 8;

  typedef logic [2:0] len_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Ones in the low (len+1) bit positions, selecting the active pattern bits.
  function automatic logic [PAT_W-1:0] len_mask(input len_t len);
    return {PAT_W{1'b1}} >> (3'd7 - len);
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Pattern-matching datapath: a 7-bit history of past serial bits, a count of
// how many of those bits are valid for the current run, and the masked
// comparator that raises the Mealy match flag from history plus the live bit.
module seq_match_core
  import seq_det_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             ovl,
  input  len_t             len,
  input  logic [PAT_W-1:0] pat,
  input  logic             d,
  output logic             z
);

  logic [6:0]       hist_q;
  logic [6:0]       hist_d;
  logic [2:0]       vcnt_q;
  logic [2:0]       vcnt_d;
  logic [PAT_W-1:0] window;

  assign window = {hist_q, d};
  assign z      = en && (vcnt_q >= len) && (((window ^ pat) & len_mask(len)) == '0);

  // Next history/valid-count: shift while enabled; a non-overlapping match discards all valid bits.
  always_comb begin
    hist_d = hist_q;
    vcnt_d = vcnt_q;
    if (clr) begin
      hist_d = '0;
      vcnt_d = '0;
    end else if (en) begin
      hist_d = window[6:0];
      if (z && !ovl) begin
        vcnt_d = '0;
      end else if (vcnt_q != 3'd7) begin
        vcnt_d = vcnt_q + 3'd1;
      end
    end
  end

  // History and valid-count registers, updated on the falling edge with synchronous active-low reset.
  always_ff @(negedge clk) begin
    if (!rst) begin
      hist_q <= '0;
      vcnt_q <= '0;
    end else begin
      hist_q <= hist_d;
      vcnt_q <= vcnt_d;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller for the sequence detector: holds the shadow configuration,
// sequences IDLE/RUN/DONE, counts matches and stops a run at the match limit.
module seq_det_ctrl
  import seq_det_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pat,
  input  len_t             cfg_len,
  input  logic             cfg_ovl,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic             start,
  input  logic             stop,
  output logic             z,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt
);

  state_t           state_q;
  state_t           state_d;
  logic [PAT_W-1:0] pat_q;
  len_t             len_q;
  logic             ovl_q;
  logic [CNT_W-1:0] limit_q;
  logic [CNT_W-1:0] match_cnt_q;
  logic [CNT_W-1:0] match_cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             limit_hit;
  logic             core_en;
  logic             core_clr;
  logic             cfg_load;

  assign cnt_inc   = (match_cnt_q == {CNT_W{1'b1}}) ? match_cnt_q : match_cnt_q + 8'd1;
  assign limit_hit = z && (limit_q != '0) && (cnt_inc == limit_q);
  assign match_cnt = match_cnt_q;

  seq_match_core u_core (
    .clk (clk),
    .rst (rst),
    .en  (core_en),
    .clr (core_clr),
    .ovl (ovl_q),
    .len (len_q),
    .pat (pat_q),
    .d   (d),
    .z   (z)
  );

  // State register; the unused encoding falls back to IDLE through the next-state logic.
  always_ff @(negedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode: stop always wins over start and over reaching the limit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start && !stop) state_d = RUN;
      RUN: begin
        if (stop) state_d = IDLE;
        else if (limit_hit) state_d = DONE;
      end
      DONE: begin
        if (stop) state_d = IDLE;
        else if (start) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs and datapath controls.
  always_comb begin
    busy     = (state_q == RUN);
    done     = (state_q == DONE);
    core_en  = (state_q == RUN);
    core_clr = ((state_q == IDLE) || (state_q == DONE)) && start && !stop;
    cfg_load = (state_q == IDLE) && cfg_we;
  end

  // Shadow configuration, writable only while idle.
  always_ff @(negedge clk) begin
    if (!rst) begin
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      limit_q <= '0;
    end else if (cfg_load) begin
      pat_q   <= cfg_pat;
      len_q   <= cfg_len;
      ovl_q   <= cfg_ovl;
      limit_q <= cfg_limit;
    end
  end

  // Match counter next value: cleared when a run starts, saturating increment on each match.
  always_comb begin
    match_cnt_d = match_cnt_q;
    if (core_clr) begin
      match_cnt_d = '0;
    end else if (z) begin
      match_cnt_d = cnt_inc;
    end
  end

  // Match counter register.
  always_ff @(negedge clk) begin
    if (!rst) begin
      match_cnt_q <= '0;
    end else begin
      match_cnt_q <= match_cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: directed scenarios plus a randomized
// run, all compared against a queue-based behavioural model of the detector.
module tb_seq_det_ctrl;

  logic       clk;
  logic       rst;
  logic       d;
  logic       cfg_we;
  logic [7:0] cfg_pat;
  logic [2:0] cfg_len;
  logic       cfg_ovl;
  logic [7:0] cfg_limit;
  logic       start;
  logic       stop;
  logic       z;
  logic       busy;
  logic       done;
  logic [7:0] match_cnt;

  int checks = 0;
  int fails  = 0;

  seq_det_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .cfg_we    (cfg_we),
    .cfg_pat   (cfg_pat),
    .cfg_len   (cfg_len),
    .cfg_ovl   (cfg_ovl),
    .cfg_limit (cfg_limit),
    .start     (start),
    .stop      (stop),
    .z         (z),
    .busy      (busy),
    .done      (done),
    .match_cnt (match_cnt)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Behavioural model: the valid bits of the run are kept as a queue, oldest first.
  typedef enum {M_IDLE, M_RUN, M_DONE} mstate_t;
  mstate_t mState = M_IDLE;
  logic [7:0] mPat   = 8'h00;
  int         mLen   = 0;
  logic       mOvl   = 1'b0;
  int         mLimit = 0;
  int         mCnt   = 0;
  bit         stream[$];

  logic zSeen;
  logic zExp;

  function automatic logic modelZ(input logic dIn);
    bit b;
    if (mState != M_RUN) return 1'b0;
    if (stream.size() < mLen) return 1'b0;
    for (int i = 0; i <= mLen; i++) begin
      b = (i == 0) ? dIn : stream[stream.size() - i];
      if (b != mPat[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task modelStep(input logic dIn, input logic stIn, input logic spIn,
                 input logic weIn, input logic rstIn, input logic m);
    if (!rstIn) begin
      mState = M_IDLE; mPat = 8'h00; mLen = 0; mOvl = 1'b0; mLimit = 0; mCnt = 0;
      stream.delete();
    end else begin
      case (mState)
        M_IDLE: begin
          if (weIn) begin
            mPat = cfg_pat; mLen = int'(cfg_len); mOvl = cfg_ovl; mLimit = int'(cfg_limit);
          end
          if (stIn && !spIn) begin
            mState = M_RUN; mCnt = 0; stream.delete();
          end
        end
        M_RUN: begin
          if (m && mCnt < 255) mCnt++;
          if (m && !mOvl) stream.delete();
          else begin
            stream.push_back(dIn);
            if (stream.size() > 8) void'(stream.pop_front());
          end
          if (spIn) mState = M_IDLE;
          else if (m && mLimit != 0 && mCnt == mLimit) mState = M_DONE;
        end
        default: begin
          if (spIn) mState = M_IDLE;
          else if (stIn) begin
            mState = M_RUN; mCnt = 0; stream.delete();
          end
        end
      endcase
    end
  endtask

  // One clock period: drive away from the falling edge, capture z just before it, step the model.
  task tick(input logic dIn, input logic stIn, input logic spIn, input logic weIn, input logic rstIn);
    @(posedge clk);
    d = dIn; start = stIn; stop = spIn; cfg_we = weIn; rst = rstIn;
    #1;
    zSeen = z;
    zExp  = modelZ(dIn);
    @(negedge clk);
    modelStep(dIn, stIn, spIn, weIn, rstIn, zExp);
    #1;
  endtask

  task applyStimulus(input logic [7:0] p, input logic [2:0] l, input logic o, input logic [7:0] lim);
    cfg_pat = p; cfg_len = l; cfg_ovl = o; cfg_limit = lim;
  endtask

  task test_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (z !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || match_cnt !== 8'd0) begin
      fails++;
      $display("[TB] FAIL reset_state: z=%b busy=%b done=%b cnt=%0d, want 0/0/0/0", z, busy, done, match_cnt);
    end
  endtask

  task test_stream(input logic o, input logic [7:0] lim, input string name);
    logic [6:0] bits;
    logic       want;
    bits = 7'b1010101;
    applyStimulus(8'h05, 3'd2, o, lim);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < ((lim != 0) ? 7 : 5); i++) begin
      tick(bits[i], 1'b0, 1'b0, 1'b0, 1'b1);
      want = (i == 2) || (o && i == 4);
      checks++;
      if (zSeen !== want) begin
        fails++;
        $display("[TB] FAIL %s_z bit%0d: got %b want %b", name, i + 1, zSeen, want);
      end
      if (lim != 0 && i == 4) begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          fails++;
          $display("[TB] FAIL %s_done: done=%b busy=%b want 1/0", name, done, busy);
        end
      end
    end
    checks++;
    if (match_cnt !== ((o) ? 8'd2 : 8'd1)) begin
      fails++;
      $display("[TB] FAIL %s_cnt: got %0d want %0d", name, match_cnt, (o) ? 2 : 1);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || match_cnt !== ((o) ? 8'd2 : 8'd1)) begin
      fails++;
      $display("[TB] FAIL %s_stop: busy=%b done=%b cnt=%0d", name, busy, done, match_cnt);
    end
  endtask

  task test_cfg_ignored();
    logic [5:0] bits;
    logic [5:0] wantZ;
    bits  = 6'b110101;
    wantZ = 6'b010100;
    applyStimulus(8'h05, 3'd2, 1'b1, 8'd0);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) applyStimulus(8'h03, 3'd2, 1'b1, 8'd0);
      tick(bits[i], 1'b0, 1'b0, (i == 2), 1'b1);
      checks++;
      if (zSeen !== wantZ[i]) begin
        fails++;
        $display("[TB] FAIL cfg_ignored_z bit%0d: got %b want %b", i + 1, zSeen, wantZ[i]);
      end
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task test_reset_midrun();
    applyStimulus(8'h05, 3'd2, 1'b0, 8'd0);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (match_cnt !== 8'd1 || busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL midrun_pre: cnt=%0d busy=%b want 1/1", match_cnt, busy);
    end
    tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (match_cnt !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midrun_reset: cnt=%0d busy=%b done=%b want 0/0/0", match_cnt, busy, done);
    end
  endtask

  task test_start_stop();
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL start_stop_idle: busy=%b want 0", busy);
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL start_run: busy=%b want 1", busy);
    end
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL start_stop_run: busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task test_saturate();
    applyStimulus(8'h01, 3'd0, 1'b0, 8'd0);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 300; i++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (zSeen !== 1'b1 || match_cnt !== 8'(mCnt)) begin
        fails++;
        $display("[TB] FAIL saturate bit%0d: z=%b cnt=%0d want 1/%0d", i, zSeen, match_cnt, mCnt);
      end
    end
    checks++;
    if (match_cnt !== 8'd255 || busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL saturate_end: cnt=%0d busy=%b want 255/1", match_cnt, busy);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task test_random();
    logic st, sp, we, rn;
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), 8'($urandom_range(0, 4)));
      we = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 9) == 0);
      sp = ($urandom_range(0, 39) == 0);
      rn = ($urandom_range(0, 299) != 0);
      tick(1'($urandom), st, sp, we, rn);
      checks++;
      if (zSeen !== zExp || busy !== (mState == M_RUN) || done !== (mState == M_DONE) ||
          match_cnt !== 8'(mCnt)) begin
        fails++;
        $display("[TB] FAIL random cyc%0d: z=%b/%b busy=%b done=%b cnt=%0d, want z=%b state=%0d cnt=%0d",
                 i, zSeen, zExp, busy, done, match_cnt, zExp, mState, mCnt);
      end
    end
  endtask

  initial begin
    rst = 1'b0; d = 1'b0; cfg_we = 1'b0; start = 1'b0; stop = 1'b0;
    applyStimulus(8'h00, 3'd0, 1'b0, 8'd0);
    test_reset();
    test_stream(1'b0, 8'd0, "nonoverlap");
    test_stream(1'b1, 8'd0, "overlap");
    test_stream(1'b1, 8'd2, "limit");
    test_cfg_ignored();
    test_reset_midrun();
    test_start_stop();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  clock; all state updates on the falling edge of clk.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: d  input  1  serial data bit, sampled every falling clk edge.
REQ-004 SHALL have port: cfg_we  input  1  configuration write strobe.
REQ-005 SHALL have port: cfg_pat  input  8  pattern; bit 0 is the most recent bit.
REQ-006 SHALL have port: cfg_len  input  3  pattern length minus 1 (0..7 gives 1..8 bits).
REQ-007 SHALL have port: cfg_ovl  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-008 SHALL have port: cfg_limit  input  8  match count that ends a run; 0 = unlimited.
REQ-009 SHALL have port: start  input  1  begin a run.
REQ-010 SHALL have port: stop  input  1  abort a run.
REQ-011 SHALL have port: z  output  1  Mealy match flag, combinational from the registered state and current d.
REQ-012 SHALL have port: busy  output  1  high in RUN.
REQ-013 SHALL have port: done  output  1  high in DONE.
REQ-014 SHALL have port: match_cnt  output  8  matches counted in the current run.

Function
REQ-015 The control FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 IDLE: on cfg_we, SHALL latch cfg_pat, cfg_len, cfg_ovl and cfg_limit into shadow registers; cfg_we in RUN or DONE SHALL be ignored.
REQ-017 IDLE + start (stop low) SHALL go to RUN and clear hist, vcnt and match_cnt; config written on the same edge SHALL apply to that run.
REQ-018 RUN: each edge SHALL shift d into the 7-bit history register hist and increment the valid-bit count vcnt, saturating at 7.
REQ-019 z SHALL be 1 iff state==RUN, vcnt>=len, and the low (len+1) bits of {hist,d} equal the low (len+1) bits of pat; otherwise z SHALL be 0.
REQ-020 On an edge where z=1, match_cnt SHALL increment, saturating at 255.
REQ-021 On a match with ovl=0, vcnt SHALL be cleared so no bit is reused; with ovl=1, hist and vcnt SHALL shift normally.
REQ-022 When limit!=0 and a match makes match_cnt equal to limit, the FSM SHALL go to DONE on that edge.
REQ-023 stop in RUN or DONE SHALL go to IDLE; match_cnt SHALL hold its value.
REQ-024 When start and stop are high on the same edge, stop SHALL win.
REQ-025 DONE: z SHALL be 0, and hist and match_cnt SHALL be frozen; start SHALL restart RUN as in REQ-017.
REQ-026 A 1-bit pattern (len=0) SHALL match on every d equal to pat[0], in both modes.

Reset
REQ-027 rst=0 at a falling edge SHALL force IDLE, hist=0, vcnt=0, match_cnt=0, pat=0, len=0, ovl=0 and limit=0, overriding all other inputs, including mid-run.
REQ-028 After reset, outputs SHALL be z=0, busy=0, done=0 and match_cnt=0.

Structure
REQ-029 Package seq_det_pkg SHALL hold the state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10), the width constants (PAT_W=8, CNT_W=8) and the length field type.
REQ-030 Sub-module seq_match_core SHALL hold hist, vcnt and the masked comparator, producing z; it SHALL be enabled and cleared by the FSM.
REQ-031 Unused state encoding 2'b11 SHALL recover to IDLE.

Verification
REQ-032 Config pat=8'h05, len=2, ovl=0, limit=0; start; d=1,0,1,0,1 -> z=1 on the 3rd bit only, match_cnt=1.
REQ-033 Same stream with ovl=1 -> z=1 on the 3rd and 5th bits, match_cnt=2.
REQ-034 ovl=1, limit=2, d=1,0,1,0,1,0,1 -> DONE after the 5th bit, done=1, z=0 on the 7th bit, match_cnt=2.
REQ-035 cfg_we with pat=8'h03 during RUN -> ignored; detection continues on 8'h05.
REQ-036 rst=0 mid-run after 1 match -> next cycle IDLE, match_cnt=0, busy=0.
REQ-037 len=0, pat=1, limit=0, 300 ones -> match_cnt saturates at 255, busy stays 1.
